// File: rtl/alias_bus_reader.sv
// Receive endpoint for the aliased transfer net: accepts NWORDS words into a small FIFO,
// scores each one against EXPECT and drains the FIFO to a valid/ready consumer.
module alias_bus_reader #(
  parameter int               WIDTH  = 32,
  parameter int               DEPTH  = 4,
  parameter int               NWORDS = 8,
  parameter logic [WIDTH-1:0] EXPECT = 32'hdeadbeef,
  parameter int               CW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bus_data,
  input  logic             bus_vld,
  output logic             bus_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [CW-1:0]    match_cnt,
  output logic [CW-1:0]    err_cnt,
  output logic             done
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = AW + 1;
  localparam int NCW = $clog2(NWORDS + 1);
  localparam logic [NCW-1:0] LAST_ACC = NCW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [NCW-1:0]   r_acc_cnt;
  logic [CW-1:0]    r_match_cnt;
  logic [CW-1:0]    r_err_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_start_run;
  logic w_last_push;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // The extra pointer bit separates a full FIFO from an empty one at equal addresses.
  assign w_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign bus_rdy     = (r_state == S_CAPTURE) && !w_full;
  assign out_vld     = !w_empty;
  assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign w_push      = bus_vld && bus_rdy;
  assign w_pop       = out_vld && out_rdy;
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_push = w_push && (r_acc_cnt == LAST_ACC);
  assign match_cnt   = r_match_cnt;
  assign err_cnt     = r_err_cnt;
  assign done        = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start)       w_next = S_CAPTURE;
      S_CAPTURE: if (w_last_push) w_next = S_DRAIN;
      S_DRAIN:   if (w_empty)     w_next = S_DONE;
      S_DONE:    if (start)       w_next = S_CAPTURE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt   <= '0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_start_run) begin
      r_acc_cnt   <= '0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (w_push) begin
      r_acc_cnt <= r_acc_cnt + NCW'(1);
      if (bus_data == EXPECT) r_match_cnt <= sat_inc(r_match_cnt);
      else                    r_err_cnt   <= sat_inc(r_err_cnt);
    end
  end

endmodule

// File: tb/tb_alias_bus_reader.sv
// Randomised bench for alias_bus_reader: two instances (CW=8 and CW=3) share stimulus and
// are scored every cycle against a queue-based model of a reader run.
module tb_alias_bus_reader;

  localparam int          WIDTH  = 32;
  localparam int          DEPTH  = 4;
  localparam int          NWORDS = 8;
  localparam logic [31:0] EXP    = 32'hdeadbeef;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bus_data;
  logic        bus_vld;
  logic        out_rdy;

  logic        bus_rdy,  bus_rdy3;
  logic [31:0] out_data, out_data3;
  logic        out_vld,  out_vld3;
  logic [7:0]  match_cnt, err_cnt;
  logic [2:0]  match_cnt3, err_cnt3;
  logic        done, done3;

  alias_bus_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NWORDS(NWORDS), .EXPECT(EXP), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus_data(bus_data), .bus_vld(bus_vld),
    .bus_rdy(bus_rdy), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .done(done));

  alias_bus_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NWORDS(NWORDS), .EXPECT(EXP), .CW(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus_data(bus_data), .bus_vld(bus_vld),
    .bus_rdy(bus_rdy3), .out_data(out_data3), .out_vld(out_vld3), .out_rdy(out_rdy),
    .match_cnt(match_cnt3), .err_cnt(err_cnt3), .done(done3));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a run is active from start until the drained FIFO has been seen empty.
  logic [31:0] m_q[$];
  bit          m_run  = 0;
  bit          m_done = 0;
  bit          m_push = 0;
  int          m_acc  = 0;
  int          m_match8 = 0, m_err8 = 0, m_match3 = 0, m_err3 = 0;

  int wmode = 0;
  bit rmode = 0;
  bit alt   = 0;

  function automatic int sat(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  function automatic bit exp_rdy();
    return m_run && (m_acc < NWORDS) && (m_q.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit push, pop, fin, st;
    int pre_size;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_run = 0; m_done = 0; m_push = 0; m_acc = 0;
        m_match8 = 0; m_err8 = 0; m_match3 = 0; m_err3 = 0;
      end else begin
        pre_size = m_q.size();
        push = bus_vld && exp_rdy();
        pop  = (pre_size > 0) && out_rdy;
        fin  = m_run && (m_acc == NWORDS) && (pre_size == 0);
        st   = start && !m_run;
        if (pop)  void'(m_q.pop_front());
        if (push) begin
          m_q.push_back(bus_data);
          m_acc++;
          if (bus_data == EXP) begin
            m_match8 = sat(m_match8, 255); m_match3 = sat(m_match3, 7);
          end else begin
            m_err8 = sat(m_err8, 255); m_err3 = sat(m_err3, 7);
          end
        end
        if (fin) begin m_run = 0; m_done = 1; end
        if (st) begin
          m_run = 1; m_done = 0; m_acc = 0;
          m_match8 = 0; m_err8 = 0; m_match3 = 0; m_err3 = 0;
        end
        m_push = push;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("bus_rdy",    bus_rdy,    32'(exp_rdy()));
        chk("bus_rdy3",   bus_rdy3,   32'(exp_rdy()));
        chk("out_vld",    out_vld,    32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
          chk("out_data",  out_data,  m_q[0]);
          chk("out_data3", out_data3, m_q[0]);
        end
        chk("match_cnt",  match_cnt,  32'(m_match8));
        chk("err_cnt",    err_cnt,    32'(m_err8));
        chk("match_cnt3", match_cnt3, 32'(m_match3));
        chk("err_cnt3",   err_cnt3,   32'(m_err3));
        chk("done",       done,       32'(m_done));
        chk("done3",      done3,      32'(m_done));
      end
    end
  end

  // Writer holds each word until it is accepted; out_rdy optionally randomised.
  initial begin
    bus_vld = 0; bus_data = '0;
    forever begin
      @(posedge clk); #1;
      if (wmode == 0) bus_vld = 0;
      else if (!bus_vld || m_push) begin
        case (wmode)
          1: begin bus_vld = 1; bus_data = EXP; end
          2: begin bus_vld = 1; bus_data = alt ? 32'h0000_0001 : EXP; alt = ~alt; end
          3: begin
            bus_vld  = ($urandom_range(0, 3) != 0);
            bus_data = $urandom;
            if (bus_data == EXP) bus_data = bus_data ^ 32'h1;
          end
          default: begin
            bus_vld  = ($urandom_range(0, 3) != 0);
            bus_data = $urandom_range(0, 1) ? EXP : $urandom;
          end
        endcase
      end
      if (rmode) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic quiet_writer(input int next_mode);
    wmode = 0;
    repeat (2) begin @(posedge clk); #1; end
    alt   = 0;
    wmode = next_mode;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(posedge clk); #1; k++; end
    chk("done_reached", done, 1);
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (m_acc < n && k < 100);
    chk("acc_reached", 32'(m_acc >= n), 1);
  endtask

  initial begin
    rst_n = 0; start = 0; out_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_rdy", bus_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_match", match_cnt, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_done", done, 0);
    rst_n = 1;

    // Constant matching writer, consumer always ready.
    out_rdy = 1;
    quiet_writer(1);
    pulse_start();
    wait_done(200);
    chk("t1_match", match_cnt, 8);
    chk("t1_err", err_cnt, 0);

    // Consumer stalled: FIFO fills after four accepts.
    out_rdy = 0;
    quiet_writer(1);
    pulse_start();
    wait_acc(4);
    repeat (3) begin @(posedge clk); #1; end
    chk("t2_bus_rdy_full", bus_rdy, 0);
    chk("t2_out_vld", out_vld, 1);
    chk("t2_out_data", out_data, EXP);
    out_rdy = 1;
    wait_done(200);
    chk("t2_match", match_cnt, 8);

    // Alternating match / mismatch.
    quiet_writer(2);
    pulse_start();
    wait_done(200);
    chk("t3_match", match_cnt, 4);
    chk("t3_err", err_cnt, 4);

    // All mismatches: CW=3 instance saturates.
    quiet_writer(3);
    pulse_start();
    wait_done(400);
    chk("t6_err3", err_cnt3, 7);
    chk("t6_match3", match_cnt3, 0);
    chk("t6_err8", err_cnt, 8);
    chk("t6_done3", done3, 1);

    // Valid before start is ignored; a second start mid-capture has no effect.
    rst_n = 0; #1; rst_n = 1;
    quiet_writer(1);
    repeat (5) begin @(posedge clk); #1; end
    chk("t4_no_early_accept", match_cnt, 0);
    pulse_start();
    repeat (3) begin @(posedge clk); #1; end
    pulse_start();
    wait_done(200);
    chk("t4_match", match_cnt, 8);
    chk("t4_err", err_cnt, 0);

    // Reset after three accepts with two words buffered.
    out_rdy = 0;
    quiet_writer(1);
    pulse_start();
    wait_acc(1);
    out_rdy = 1;
    @(posedge clk); #1;
    out_rdy = 0;
    @(posedge clk); #1;
    chk("t5_pre_match", match_cnt, 3);
    chk("t5_pre_vld", out_vld, 1);
    wmode = 0;
    rst_n = 0;
    #1;
    chk("t5_out_vld", out_vld, 0);
    chk("t5_bus_rdy", bus_rdy, 0);
    chk("t5_match", match_cnt, 0);
    chk("t5_err", err_cnt, 0);
    chk("t5_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_idle_rdy", bus_rdy, 0);

    // Randomised runs with random backpressure and stray start pulses.
    rmode = 1;
    quiet_writer(4);
    for (int r = 0; r < 20; r++) begin
      pulse_start();
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 1)) pulse_start();
      wait_done(400);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    rmode = 0;
    wmode = 0;
    repeat (3) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
